bif_bus_ctl_n: RTL and testbench
================================

Name: bif_bus_ctl_n

Overview:
- Parametrised successor to the board's bus-interface control path.
- Arbitrates NCH local requestors onto the shared bus (e.g. CPU, cache, IO, refresh) with selectable fixed or round-robin priority and a semaphore lock.
- Sequences the address/data handshake: BAPR, then BDAP, then wait for BDRY, then release.
- Adds a bus timeout and per-channel completion/error reporting that the previous fixed-channel control lacked.

Parameters:
- NCH, 4: number of requesting channels (2..8).
- RR_MODE, 1: 1 = round-robin priority; 0 = fixed priority, lowest index wins.
- APR_CYCLES, 2: cycles BAPR_n is held low before BDAP_n asserts (1..15).
- TOUT_CYCLES, 64: cycle budget for BDRY_n to assert (DAP) or deassert (REL) (4..1023).
- LOCK_EN, 1: enables the LOCK inputs (semaphore back-to-back cycles).

Ports:
- OSC  in  1  system clock; all logic on the rising edge.
- CLEAR  in  1  synchronous active-high reset.
- REQ  in  NCH  per-channel bus request; level, held until DONE or ERR.
- LOCK  in  NCH  per-channel hold-bus request for the next cycle; ignored when LOCK_EN=0.
- BDRY_n  in  1  bus data ready, active low; asynchronous; 2-flop synchronised internally.
- BERROR_n  in  1  bus error, active low; asynchronous; 2-flop synchronised internally.
- GNT  out  NCH  one-hot grant; held from APR through REL.
- BAPR_n  out  1  address present, active low.
- BDAP_n  out  1  data present, active low.
- DONE  out  NCH  one-cycle pulse to the granted channel on normal completion.
- ERR  out  NCH  one-cycle pulse to the granted channel on BERROR or timeout.
- TMO  out  1  one-cycle pulse whenever a timeout fires.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset: CLEAR sampled high forces IDLE on that edge.
  - GNT=0, DONE=0, ERR=0, TMO=0, BUSY=0, BAPR_n=1, BDAP_n=1.
  - Round-robin pointer=0, counters=0, sync flops=1.
  - Applies mid-cycle too; no DONE/ERR is issued for an aborted cycle.
- States: IDLE, APR, DAP, REL.
- IDLE: if any REQ is high, select a winner.
  - RR_MODE=1: first requestor at index >= ptr, wrapping modulo NCH. ptr = winner+1 (mod NCH), updated at grant.
  - RR_MODE=0: lowest requesting index wins.
  - Next edge: GNT[w]=1, BAPR_n=0, go to APR. Latency from REQ to GNT is 1 cycle.
- APR: count APR_CYCLES cycles. On the last one: BAPR_n=1, BDAP_n=0, counter cleared, go to DAP.
- DAP: each cycle, evaluate the synced inputs in priority order:
  1. BERROR low: ERR pulse, go to REL.
  2. BDRY low: DONE pulse, go to REL.
  3. Counter reaches TOUT_CYCLES-1: ERR and TMO pulse, go to REL.
  4. Otherwise increment the counter.
  - BDRY and timeout in the same cycle: BDRY wins, giving DONE and no TMO.
- REL: BDAP_n=1 on entry; counter cleared. Wait for synced BDRY_n=1.
  - On exit, if LOCK_EN and LOCK[w] and REQ[w]: stay granted, BAPR_n=0, go to APR. No rearbitration and ptr unchanged.
  - Otherwise GNT=0, go to IDLE.
  - If BDRY_n is still low after TOUT_CYCLES: TMO pulse (no second ERR), force GNT=0, go to IDLE.
- REQ dropping after grant does not abort the cycle; the bus cycle completes normally.
- Only one of DONE or ERR pulses per bus cycle.
- Minimum back-to-back cycle for the same channel (locked): APR_CYCLES + 1 + BDRY sync latency (2) + release sync (2).
- GNT is never multi-hot; BAPR_n and BDAP_n are never both low.

Decomposition:
- Shared package bif_pkg:
  - state enum (IDLE/APR/DAP/REL).
  - clog2-based counter-width constants.
  - active-low level constants.
- Natural sub-module: bif_rr_arb. Combinational round-robin/fixed selector with a registered pointer. Parameters NCH and RR_MODE.
- The 2-flop synchroniser reuses the existing sync cell.

Test Plan:
- NCH=4, RR=1: REQ=4'b1111 held, BDRY_n answers 3 cycles after BDAP -> grants in order 0,1,2,3,0; each REQ->GNT latency is 1 cycle; each GNT gets exactly one DONE.
- RR=0: REQ=4'b1010 -> GNT=4'b0010 on every cycle; channel 3 starved while ch1 requests.
- BDRY_n held high, TOUT_CYCLES=8 -> ERR[w] and TMO pulse 8 cycles after BDAP_n falls; BDAP_n=1 next cycle; return to IDLE.
- BERROR_n and BDRY_n fall together in DAP -> ERR pulse, no DONE; BDRY_n falling on the timeout cycle -> DONE, no TMO.
- LOCK[2]=1, REQ[2]=1, REQ[0]=1 -> two consecutive ch2 cycles without GNT dropping; then ch0 is granted.
- CLEAR=1 during DAP -> next edge: GNT=0, BAPR_n=BDAP_n=1, BUSY=0, no DONE/ERR; REQ after release -> grant from ptr 0.

Source files
------------

// File: rtl/bif_pkg.sv
// Shared types and constants for the bus-interface control path.
// Imported by the arbiter and the bus controller.
package bif_pkg;

  typedef logic [1:0] bif_state_t;

  localparam bif_state_t ST_IDLE = 2'd0;
  localparam bif_state_t ST_APR  = 2'd1;
  localparam bif_state_t ST_DAP  = 2'd2;
  localparam bif_state_t ST_REL  = 2'd3;

  localparam logic ACT_N  = 1'b0;
  localparam logic IDLE_N = 1'b1;

  // Counter holds values up to max(a,b)-1.
  function automatic int cnt_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/bif_rr_arb.sv
// Round-robin or fixed-priority one-hot selector.
// Pointer advances past the winner when adv is high.
module bif_rr_arb #(
  parameter int NCH     = 4,
  parameter bit RR_MODE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] req,
  input  logic           adv,
  output logic [NCH-1:0] gnt,
  output logic           any
);

  localparam int IW = $clog2(NCH);

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    base, win;
  logic [2*NCH-1:0] dbl;
  logic [NCH-1:0]   rot;
  logic [IW:0]      sum;

  always_comb begin
    base = RR_MODE ? ptr_q : '0;
    dbl  = {req, req};
    rot  = NCH'(dbl >> base);
    any  = 1'b0;
    sum  = '0;
    // Descending scan so the lowest rotated index is kept.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, base} + (IW+1)'(i);
        any = 1'b1;
      end
    end
    if (sum >= (IW+1)'(NCH)) sum = sum - (IW+1)'(NCH);
    win = sum[IW-1:0];
    gnt = any ? (NCH'(1) << win) : '0;
    ptr_d = ptr_q;
    if (RR_MODE && adv && any)
      ptr_d = (win == IW'(NCH - 1)) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bif_sync2.sv
// Two-flop synchroniser cell for asynchronous bus strobes.
// Resets to a selectable idle level.
module bif_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1_q, s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/bif_bus_ctl_n.sv
// Bus-interface control: arbitration, APR/DAP handshake,
// timeout and per-channel completion reporting.
module bif_bus_ctl_n
  import bif_pkg::*;
#(
  parameter int NCH         = 4,
  parameter bit RR_MODE     = 1'b1,
  parameter int APR_CYCLES  = 2,
  parameter int TOUT_CYCLES = 64,
  parameter bit LOCK_EN     = 1'b1
) (
  input  logic           OSC,
  input  logic           CLEAR,
  input  logic [NCH-1:0] REQ,
  input  logic [NCH-1:0] LOCK,
  input  logic           BDRY_n,
  input  logic           BERROR_n,
  output logic [NCH-1:0] GNT,
  output logic           BAPR_n,
  output logic           BDAP_n,
  output logic [NCH-1:0] DONE,
  output logic [NCH-1:0] ERR,
  output logic           TMO,
  output logic           BUSY
);

  localparam int CW = cnt_w(APR_CYCLES, TOUT_CYCLES);

  bif_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [NCH-1:0] done_q, done_d;
  logic [NCH-1:0] err_q, err_d;
  logic           bapr_q, bapr_d;
  logic           bdap_q, bdap_d;
  logic           tmo_q, tmo_d;

  logic           bdry_s, berr_s;
  logic [NCH-1:0] arb_gnt, lock_m;
  logic           arb_any, relock;

  bif_sync2 #(.RST_VAL(IDLE_N)) u_sync_bdry (
    .clk(OSC), .rst(CLEAR), .d(BDRY_n), .q(bdry_s)
  );

  bif_sync2 #(.RST_VAL(IDLE_N)) u_sync_berr (
    .clk(OSC), .rst(CLEAR), .d(BERROR_n), .q(berr_s)
  );

  bif_rr_arb #(.NCH(NCH), .RR_MODE(RR_MODE)) u_arb (
    .clk(OSC),
    .rst(CLEAR),
    .req(REQ),
    .adv(state_q == ST_IDLE),
    .gnt(arb_gnt),
    .any(arb_any)
  );

  assign lock_m = LOCK_EN ? LOCK : '0;
  assign relock = |(gnt_q & lock_m & REQ);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    bapr_d  = bapr_q;
    bdap_d  = bdap_q;
    done_d  = '0;
    err_d   = '0;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_gnt;
          bapr_d  = ACT_N;
          cnt_d   = '0;
          state_d = ST_APR;
        end
      end
      ST_APR: begin
        if (cnt_q == CW'(APR_CYCLES - 1)) begin
          bapr_d  = IDLE_N;
          bdap_d  = ACT_N;
          cnt_d   = '0;
          state_d = ST_DAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DAP: begin
        // Error beats ready; ready beats a same-cycle timeout.
        if (berr_s == ACT_N) begin
          err_d   = gnt_q;
          state_d = ST_REL;
        end else if (bdry_s == ACT_N) begin
          done_d  = gnt_q;
          state_d = ST_REL;
        end else if (cnt_q == CW'(TOUT_CYCLES - 1)) begin
          err_d   = gnt_q;
          tmo_d   = 1'b1;
          state_d = ST_REL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (state_d == ST_REL) begin
          bdap_d = IDLE_N;
          cnt_d  = '0;
        end
      end
      ST_REL: begin
        if (bdry_s == IDLE_N) begin
          cnt_d = '0;
          if (relock) begin
            bapr_d  = ACT_N;
            state_d = ST_APR;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CW'(TOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          gnt_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OSC) begin
    if (CLEAR) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      bapr_q  <= IDLE_N;
      bdap_q  <= IDLE_N;
      done_q  <= '0;
      err_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      bapr_q  <= bapr_d;
      bdap_q  <= bdap_d;
      done_q  <= done_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign GNT    = gnt_q;
  assign BAPR_n = bapr_q;
  assign BDAP_n = bdap_q;
  assign DONE   = done_q;
  assign ERR    = err_q;
  assign TMO    = tmo_q;
  assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bif_bus_ctl_n.sv
// Directed bench for bif_bus_ctl_n: a round-robin and a fixed-priority
// instance, each with a simple bus-target responder.
module tb_bif_bus_ctl_n;

  logic       OSC = 1'b0;
  logic       CLEAR = 1'b1;
  logic [3:0] req_a = '0, lock_a = '0;
  logic [3:0] req_b = '0, lock_b = '0;
  logic       bdry_a = 1'b1, berr_a = 1'b1;
  logic       bdry_b = 1'b1, berr_b = 1'b1;

  logic [3:0] gnt_a, done_a, err_a;
  logic       bapr_a, bdap_a, tmo_a, busy_a;
  logic [3:0] gnt_b, done_b, err_b;
  logic       bapr_b, bdap_b, tmo_b, busy_b;

  int errors = 0;
  int checks = 0;
  int dly_a = 3, dly_b = 3;
  bit eflag_a = 1'b0;
  int pc_a = 0, pc_b = 0;

  always #5 OSC = ~OSC;

  bif_bus_ctl_n #(
    .NCH(4), .RR_MODE(1'b1), .APR_CYCLES(2),
    .TOUT_CYCLES(8), .LOCK_EN(1'b1)
  ) u_rr (
    .OSC(OSC), .CLEAR(CLEAR), .REQ(req_a), .LOCK(lock_a),
    .BDRY_n(bdry_a), .BERROR_n(berr_a),
    .GNT(gnt_a), .BAPR_n(bapr_a), .BDAP_n(bdap_a),
    .DONE(done_a), .ERR(err_a), .TMO(tmo_a), .BUSY(busy_a)
  );

  bif_bus_ctl_n #(
    .NCH(4), .RR_MODE(1'b0), .APR_CYCLES(2),
    .TOUT_CYCLES(8), .LOCK_EN(1'b1)
  ) u_fx (
    .OSC(OSC), .CLEAR(CLEAR), .REQ(req_b), .LOCK(lock_b),
    .BDRY_n(bdry_b), .BERROR_n(berr_b),
    .GNT(gnt_b), .BAPR_n(bapr_b), .BDAP_n(bdap_b),
    .DONE(done_b), .ERR(err_b), .TMO(tmo_b), .BUSY(busy_b)
  );

  // Target: pulls BDRY_n low dly samples after BDAP_n falls (-1: never).
  always @(posedge OSC) begin
    #1;
    if (bdap_a == 1'b0) begin
      pc_a++;
      if (dly_a >= 0 && pc_a >= dly_a) begin
        bdry_a = 1'b0;
        if (eflag_a) berr_a = 1'b0;
      end
    end else begin
      pc_a = 0; bdry_a = 1'b1; berr_a = 1'b1;
    end
    if (bdap_b == 1'b0) begin
      pc_b++;
      if (dly_b >= 0 && pc_b >= dly_b) bdry_b = 1'b0;
    end else begin
      pc_b = 0; bdry_b = 1'b1; berr_b = 1'b1;
    end
  end

  always @(negedge OSC) begin
    if (!CLEAR) begin
      checks++;
      if ($countones(gnt_a) > 1 || $countones(gnt_b) > 1 ||
          (!bapr_a && !bdap_a) || (!bapr_b && !bdap_b)) begin
        errors++;
        $display("FAIL bus_excl gnt_a=%b gnt_b=%b apr_a=%b dap_a=%b apr_b=%b dap_b=%b",
                 gnt_a, gnt_b, bapr_a, bdap_a, bapr_b, bdap_b);
      end
    end
  end

  task automatic tick();
    @(posedge OSC);
    #1;
  endtask

  task automatic do_reset();
    CLEAR = 1'b1;
    req_a = '0; lock_a = '0; req_b = '0; lock_b = '0;
    eflag_a = 1'b0; dly_a = 3; dly_b = 3;
    tick();
    tick();
    CLEAR = 1'b0;
  endtask

  // Waits for a grant, then counts pulses until GNT changes.
  task automatic run_cycle(input bit sel, output logic [3:0] g,
                           output int nd, output int ne, output int nt,
                           output int gap, output bit ok);
    ok = 1'b1; gap = 0; nd = 0; ne = 0; nt = 0;
    while (((sel ? gnt_b : gnt_a) == 4'b0) && gap < 40) begin
      tick();
      gap++;
    end
    g = sel ? gnt_b : gnt_a;
    if (g == 4'b0) begin
      ok = 1'b0;
      return;
    end
    for (int n = 0; n < 200; n++) begin
      tick();
      nd += $countones(sel ? done_b : done_a);
      ne += $countones(sel ? err_b : err_a);
      nt += int'(sel ? tmo_b : tmo_a);
      if ((sel ? gnt_b : gnt_a) != g) return;
    end
    ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] g; int nd, ne, nt, gap; bit ok;
    do_reset();
    checks++;
    if ({gnt_a, bapr_a, bdap_a, busy_a, done_a, err_a, tmo_a} !==
        {4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL reset_state gnt=%b apr=%b dap=%b busy=%b done=%b err=%b tmo=%b exp 0000 1 1 0 0000 0000 0",
               gnt_a, bapr_a, bdap_a, busy_a, done_a, err_a, tmo_a);
    end
    req_a = 4'b0100;
    tick();
    checks++;
    if ({gnt_a, bapr_a, bdap_a, busy_a} !== {4'b0100, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL req_latency gnt=%b apr=%b dap=%b busy=%b exp 0100 0 1 1",
               gnt_a, bapr_a, bdap_a, busy_a);
    end
    req_a = 4'b0000;
    run_cycle(1'b0, g, nd, ne, nt, gap, ok);
    checks++;
    if (!ok || nd != 1 || ne != 0 || gap != 0) begin
      errors++;
      $display("FAIL req_drop ok=%0d done=%0d err=%0d gap=%0d exp 1 1 0 0",
               ok, nd, ne, gap);
    end
  endtask

  task automatic test_rr_order();
    logic [3:0] g, exp_g; int nd, ne, nt, gap; bit ok;
    do_reset();
    req_a = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      run_cycle(1'b0, g, nd, ne, nt, gap, ok);
      checks++;
      if (!ok || g !== exp_g) begin
        errors++;
        $display("FAIL rr_gnt[%0d] got=%b exp=%b ok=%0d", k, g, exp_g, ok);
      end
      checks++;
      if (gap != 1) begin
        errors++;
        $display("FAIL rr_latency[%0d] got=%0d exp=1", k, gap);
      end
      checks++;
      if (nd != 1 || ne != 0) begin
        errors++;
        $display("FAIL rr_done[%0d] done=%0d err=%0d exp 1 0", k, nd, ne);
      end
    end
    req_a = 4'b0000;
  endtask

  task automatic test_fixed();
    logic [3:0] g; int nd, ne, nt, gap; bit ok;
    do_reset();
    req_b = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b1, g, nd, ne, nt, gap, ok);
      checks++;
      if (!ok || g !== 4'b0010 || nd != 1) begin
        errors++;
        $display("FAIL fixed_gnt[%0d] got=%b done=%0d exp 0010 1", k, g, nd);
      end
    end
    req_b = 4'b1000;
    run_cycle(1'b1, g, nd, ne, nt, gap, ok);
    req_b = 4'b0000;
    checks++;
    if (!ok || g !== 4'b1000 || nd != 1) begin
      errors++;
      $display("FAIL fixed_ch3 got=%b done=%0d exp 1000 1", g, nd);
    end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    dly_a = -1;
    req_a = 4'b0001;
    n = 0;
    while (bdap_a !== 1'b0 && n < 20) begin tick(); n++; end
    n = 0;
    while (err_a == 4'b0 && n < 30) begin tick(); n++; end
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL tmo_delay got=%0d exp=8", n);
    end
    checks++;
    if ({err_a, tmo_a, done_a, bdap_a} !== {4'b0001, 1'b1, 4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL tmo_pulse err=%b tmo=%b done=%b dap=%b exp 0001 1 0000 1",
               err_a, tmo_a, done_a, bdap_a);
    end
    req_a = 4'b0000;
    tick();
    checks++;
    if ({gnt_a, bdap_a, busy_a, err_a, tmo_a} !==
        {4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL tmo_release gnt=%b dap=%b busy=%b err=%b tmo=%b exp 0000 1 0 0000 0",
               gnt_a, bdap_a, busy_a, err_a, tmo_a);
    end
    dly_a = 3;
  endtask

  task automatic test_err_prio();
    logic [3:0] g; int nd, ne, nt, gap; bit ok;
    do_reset();
    eflag_a = 1'b1;
    req_a = 4'b0010;
    run_cycle(1'b0, g, nd, ne, nt, gap, ok);
    req_a = 4'b0000;
    eflag_a = 1'b0;
    checks++;
    if (!ok || g !== 4'b0010 || ne != 1 || nd != 0 || nt != 0) begin
      errors++;
      $display("FAIL berr_prio g=%b err=%0d done=%0d tmo=%0d exp 0010 1 0 0",
               g, ne, nd, nt);
    end
    dly_a = 6;
    req_a = 4'b0100;
    run_cycle(1'b0, g, nd, ne, nt, gap, ok);
    req_a = 4'b0000;
    checks++;
    if (!ok || nd != 1 || ne != 0 || nt != 0) begin
      errors++;
      $display("FAIL rdy_on_tmo done=%0d err=%0d tmo=%0d exp 1 0 0", nd, ne, nt);
    end
    dly_a = 7;
    req_a = 4'b0100;
    run_cycle(1'b0, g, nd, ne, nt, gap, ok);
    req_a = 4'b0000;
    checks++;
    if (!ok || nd != 0 || ne != 1 || nt != 1) begin
      errors++;
      $display("FAIL rdy_after_tmo done=%0d err=%0d tmo=%0d exp 0 1 1", nd, ne, nt);
    end
    dly_a = 3;
  endtask

  task automatic test_lock();
    logic [3:0] g; int nd, ne, nt, gap, n; bit ok;
    do_reset();
    req_a = 4'b0010;
    run_cycle(1'b0, g, nd, ne, nt, gap, ok);
    lock_a = 4'b0100;
    req_a = 4'b0101;
    n = 0;
    while (gnt_a == 4'b0 && n < 20) begin tick(); n++; end
    checks++;
    if (gnt_a !== 4'b0100) begin
      errors++;
      $display("FAIL lock_first got=%b exp=0100", gnt_a);
    end
    nd = 0;
    for (n = 0; n < 100; n++) begin
      tick();
      if (gnt_a != 4'b0100) break;
      if (done_a != 4'b0) begin
        nd++;
        if (nd == 2) begin
          lock_a = 4'b0000;
          req_a = 4'b0001;
        end
      end
    end
    checks++;
    if (nd != 2 || gnt_a !== 4'b0000) begin
      errors++;
      $display("FAIL lock_b2b done=%0d gnt=%b exp 2 0000", nd, gnt_a);
    end
    run_cycle(1'b0, g, nd, ne, nt, gap, ok);
    req_a = 4'b0000;
    checks++;
    if (!ok || g !== 4'b0001 || gap != 1) begin
      errors++;
      $display("FAIL lock_next got=%b gap=%0d exp 0001 1", g, gap);
    end
  endtask

  task automatic test_clear_mid();
    logic [3:0] g; int nd, ne, nt, gap, n; bit ok;
    do_reset();
    dly_a = -1;
    req_a = 4'b0010;
    n = 0;
    while (bdap_a !== 1'b0 && n < 20) begin tick(); n++; end
    tick();
    tick();
    CLEAR = 1'b1;
    req_a = 4'b0000;
    tick();
    checks++;
    if ({gnt_a, bapr_a, bdap_a, busy_a, done_a, err_a, tmo_a} !==
        {4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL clear_mid gnt=%b apr=%b dap=%b busy=%b done=%b err=%b tmo=%b exp 0000 1 1 0 0000 0000 0",
               gnt_a, bapr_a, bdap_a, busy_a, done_a, err_a, tmo_a);
    end
    CLEAR = 1'b0;
    dly_a = 3;
    nd = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      nd += $countones(done_a) + $countones(err_a) + int'(tmo_a);
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL clear_no_pulse got=%0d exp=0", nd);
    end
    req_a = 4'b1001;
    tick();
    checks++;
    if (gnt_a !== 4'b0001) begin
      errors++;
      $display("FAIL clear_ptr got=%b exp=0001", gnt_a);
    end
    req_a = 4'b0000;
    run_cycle(1'b0, g, nd, ne, nt, gap, ok);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rr_order();
    test_fixed();
    test_timeout();
    test_err_prio();
    test_lock();
    test_clear_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
